// File: rtl/store_align_pkg.sv
// Shared memory-access definitions: access sizes, FSM states and the write-beat payload.
// The load-side extend logic uses the same definitions.
package store_align_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = 4;
    localparam int unsigned OFF_W  = 2;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10,
        SIZE_RSVD = 2'b11
    } mem_size_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        BEAT0 = 2'b01,
        BEAT1 = 2'b10
    } mem_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [BE_W-1:0]   be;
    } mem_beat_t;

endpackage

// File: rtl/store_lane_gen.sv
// Places store data and byte mask into a two-word lane window starting at the byte offset.
module store_lane_gen
    import store_align_pkg::*;
(
    input  logic [OFF_W-1:0]    off,
    input  logic [1:0]          size,
    input  logic [DATA_W-1:0]   data,
    output logic [2*BE_W-1:0]   mask,
    output logic [2*DATA_W-1:0] lane
);

    logic [2*BE_W-1:0] base_mask;

    always_comb begin
        base_mask = '0;
        case (size)
            SIZE_BYTE: base_mask = 8'b0000_0001;
            SIZE_HALF: base_mask = 8'b0000_0011;
            SIZE_WORD: base_mask = 8'b0000_1111;
            default:   base_mask = '0;
        endcase
        mask = base_mask << off;
        lane = {{DATA_W{1'b0}}, data} << {off, 3'b000};
    end

endmodule

// File: rtl/store_align.sv
// Store alignment: turns a byte/half/word store at any byte address into one or two
// word-aligned memory write beats with byte enables.
module store_align
    import store_align_pkg::*;
#(
    parameter bit ALLOW_MISALIGNED = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_data,
    input  logic [1:0]        req_size,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [BE_W-1:0]   mem_be,
    output logic              done,
    output logic              err
);

    mem_state_e        state_q, state_d;
    mem_beat_t         beat_q, beat_d;
    logic [DATA_W-1:0] hi_wdata_q, hi_wdata_d;
    logic [BE_W-1:0]   hi_be_q, hi_be_d;
    logic              mem_valid_d, done_d, err_d, req_ready_d;

    logic [2*BE_W-1:0]   mask;
    logic [2*DATA_W-1:0] lane;
    logic                crossing, reject;

    store_lane_gen u_lane_gen (
        .off  (req_addr[OFF_W-1:0]),
        .size (req_size),
        .data (req_data),
        .mask (mask),
        .lane (lane)
    );

    assign crossing  = (mask[2*BE_W-1:BE_W] != '0);
    assign reject    = (req_size == SIZE_RSVD) || (crossing && (ALLOW_MISALIGNED == 1'b0));
    assign mem_addr  = beat_q.addr;
    assign mem_wdata = beat_q.wdata;
    assign mem_be    = beat_q.be;

    // Next-state and next-output logic; the upper lane half is parked for a possible second beat.
    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        hi_wdata_d  = hi_wdata_q;
        hi_be_d     = hi_be_q;
        mem_valid_d = mem_valid;
        req_ready_d = req_ready;
        done_d      = 1'b0;
        err_d       = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready_d = 1'b1;
                if (req_valid && req_ready) begin
                    if (reject) begin
                        err_d = 1'b1;
                    end else begin
                        state_d      = BEAT0;
                        mem_valid_d  = 1'b1;
                        req_ready_d  = 1'b0;
                        beat_d.addr  = {req_addr[ADDR_W-1:OFF_W], 2'b00};
                        beat_d.wdata = lane[DATA_W-1:0];
                        beat_d.be    = mask[BE_W-1:0];
                        hi_wdata_d   = lane[2*DATA_W-1:DATA_W];
                        hi_be_d      = mask[2*BE_W-1:BE_W];
                    end
                end
            end
            BEAT0: begin
                if (mem_ready) begin
                    if (hi_be_q != '0) begin
                        state_d      = BEAT1;
                        beat_d.addr  = beat_q.addr + ADDR_W'(4);
                        beat_d.wdata = hi_wdata_q;
                        beat_d.be    = hi_be_q;
                    end else begin
                        state_d     = IDLE;
                        mem_valid_d = 1'b0;
                        req_ready_d = 1'b1;
                        done_d      = 1'b1;
                    end
                end
            end
            BEAT1: begin
                if (mem_ready) begin
                    state_d     = IDLE;
                    mem_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                    done_d      = 1'b1;
                end
            end
            default: begin
                state_d     = IDLE;
                mem_valid_d = 1'b0;
                req_ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            beat_q     <= '0;
            hi_wdata_q <= '0;
            hi_be_q    <= '0;
            mem_valid  <= 1'b0;
            req_ready  <= 1'b1;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            hi_wdata_q <= hi_wdata_d;
            hi_be_q    <= hi_be_d;
            mem_valid  <= mem_valid_d;
            req_ready  <= req_ready_d;
            done       <= done_d;
            err        <= err_d;
        end
    end

endmodule

// File: doc/store_align.md
STORE_ALIGN -- requirements
Module: store_align

Interface
REQ-001 SHALL have parameter ALLOW_MISALIGNED, default 1, meaning: 1 = split word-crossing stores into two beats; 0 = reject them with err.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-004 SHALL have port req_valid, input, 1, store request present.
REQ-005 SHALL have port req_ready, output, 1, block can accept a request.
REQ-006 SHALL have port req_addr, input, 32, byte address of the store.
REQ-007 SHALL have port req_data, input, 32, store data, right-justified (byte in [7:0], half in [15:0]).
REQ-008 SHALL have port req_size, input, 2, access size: 00 byte, 01 half, 10 word, 11 reserved.
REQ-009 SHALL have port mem_valid, output, 1, memory write beat present.
REQ-010 SHALL have port mem_ready, input, 1, memory accepts the beat.
REQ-011 SHALL have port mem_addr, output, 32, word-aligned write address; bits [1:0] always 0.
REQ-012 SHALL have port mem_wdata, output, 32, lane-placed write data.
REQ-013 SHALL have port mem_be, output, 4, byte enables; bit i qualifies mem_wdata[8i+7:8i].
REQ-014 SHALL have port done, output, 1, one-cycle pulse: store fully written.
REQ-015 SHALL have port err, output, 1, one-cycle pulse: request rejected, no write issued.

Function
REQ-016 SHALL implement FSM states IDLE, BEAT0, BEAT1; req_ready = 1 only in IDLE.
REQ-017 SHALL accept a request on req_valid && req_ready and capture addr, data and size in that cycle.
REQ-018 SHALL form the 8-bit mask as byte 0001, half 0011, word 1111, shifted left by off = req_addr[1:0].
REQ-019 SHALL form the 64-bit lane data as {32'b0, req_data} shifted left by 8*off.
REQ-020 SHALL mark a request as crossing when mask[7:4] != 0 (half at off 3; word at off 1..3).
REQ-021 SHALL, for a valid request, enter BEAT0 the cycle after acceptance, driving mem_valid=1 with these registered values: mem_addr = {req_addr[31:2],2'b00}, mem_wdata = lane[31:0], mem_be = mask[3:0].
REQ-022 SHALL hold mem_addr, mem_wdata, mem_be and mem_valid stable while mem_valid && !mem_ready.
REQ-023 SHALL, on the BEAT0 handshake of a crossing request, go to BEAT1 and drive these values: mem_addr = previous mem_addr + 4 (wrapping modulo 2^32), mem_wdata = lane[63:32], mem_be = mask[7:4].
REQ-024 SHALL, on the final beat handshake, return to IDLE, pulse done=1 in the following cycle, and deassert mem_valid in that same cycle.
REQ-025 SHALL accept a new request in the cycle done is high (back-to-back), giving one write beat every 2 cycles minimum.
REQ-026 SHALL reject req_size=11, and a crossing request when ALLOW_MISALIGNED=0: stay in IDLE, pulse err=1 in the next cycle, issue no beat, do not pulse done.
REQ-027 SHALL never assert done and err in the same cycle.
REQ-028 SHALL ignore req_* inputs outside IDLE; it has no queueing.

Reset
REQ-029 SHALL, while rst=1 at a clock edge, enter IDLE and set mem_valid=0, done=0, err=0, mem_addr=0, mem_wdata=0, mem_be=0.
REQ-030 SHALL give req_ready=1 in the first cycle after rst deasserts.
REQ-031 SHALL, on rst mid-transaction (BEAT0/BEAT1, stalled or not), abandon the store: no further beats, no done.

Structure
REQ-032 SHALL take the size encodings (BYTE, HALF, WORD) and FSM state encodings from the shared memory-access package, which the load-side extend logic also uses.
REQ-033 SHALL implement the mask/lane computation as one combinational sub-module, store_lane_gen (inputs: off, size, data; outputs: mask[7:0], lane[63:0]).

Verification
REQ-034 Byte store: addr 0x1003, data 0x000000AB, size 00, mem_ready=1 -> one beat: addr 0x1000, wdata 0xAB000000, be 1000; done pulses.
REQ-035 Half stall: addr 0x2002, data 0x1234, size 01, mem_ready held 0 for 3 cycles -> beat stays stable (addr 0x2000, wdata 0x12340000, be 1100) until handshake; then done.
REQ-036 Misaligned word, ALLOW_MISALIGNED=1: addr 0x3001, data 0xDDCCBBAA -> beat0 (0x3000, 0xCCBBAA00, be 1110), then beat1 (0x3004, 0x000000DD, be 0001), then done.
REQ-037 Reject: size 11 at any address, and ALLOW_MISALIGNED=0 with half at 0x4003 -> err pulses, mem_valid stays 0, done stays 0.
REQ-038 Reset in BEAT1 with mem_ready=0 -> next cycle mem_valid=0, req_ready=1, no done; back-to-back aligned words after this -> each accepted in the cycle its predecessor's done is high.
